// File: rtl/ysyx_25040111_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_scoreboard_pkg
// Purpose  : Shared constants and types for the register scoreboard.
//            SB_NREG  - number of tracked architectural registers (RV32E)
//            SB_CNT_W - width of each per-register pending-write counter
//            SB_CNT_MAX - largest count a register may hold
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_25040111_scoreboard_pkg;

    localparam int SB_NREG    = 16;
    localparam int SB_CNT_W   = 2;
    localparam int SB_CNT_MAX = (1 << SB_CNT_W) - 1;

    // Architectural register index as carried on the decode/retire buses.
    // Only the low bits addressing SB_NREG registers are significant.
    typedef logic [4:0] arch_idx_t;

endpackage : ysyx_25040111_scoreboard_pkg
`default_nettype wire

// File: rtl/ysyx_25040111_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_scoreboard_if
// Purpose  : Decode-issue / execute / write-back handshake bundle seen by the
//            scoreboard.
//            master : IDU/EXU/WBU side (drives decode fields, ex_ready, retire)
//            slave  : scoreboard side (drives id_ready, ex_valid)
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_25040111_scoreboard_if;
    import ysyx_25040111_scoreboard_pkg::*;

    logic      id_valid;
    logic      id_ready;
    arch_idx_t id_rs1;
    logic      id_rs1_en;
    arch_idx_t id_rs2;
    logic      id_rs2_en;
    arch_idx_t id_rd;
    logic      id_rd_en;
    logic      ex_valid;
    logic      ex_ready;
    logic      wb_valid;
    arch_idx_t wb_rd;

    modport master (
        output id_valid, id_rs1, id_rs1_en, id_rs2, id_rs2_en, id_rd, id_rd_en,
        output ex_ready, wb_valid, wb_rd,
        input  id_ready, ex_valid
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_en, id_rs2, id_rs2_en, id_rd, id_rd_en,
        input  ex_ready, wb_valid, wb_rd,
        output id_ready, ex_valid
    );

endinterface : ysyx_25040111_scoreboard_if
`default_nettype wire

// File: rtl/ysyx_25040111_scoreboard_sb_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_sb_cnt
// Purpose  : One saturating up/down pending-write counter.
//            clock, reset (async, active low)
//            inc  - one more write outstanding
//            dec  - one outstanding write retired
//            zero - counter is 0
//            full - counter is at its maximum
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25040111_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic inc,
    input  wire logic dec,
    output logic      zero,
    output logic      full
);

    localparam logic [CNT_W-1:0] C_MAX = '1;
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_inc_ok;
    logic             w_dec_ok;

    assign zero = (r_cnt == '0);
    assign full = (r_cnt == C_MAX);

    // Saturate at both ends; a simultaneous legal inc and dec cancel.
    assign w_inc_ok = inc & ~full;
    assign w_dec_ok = dec & ~zero;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_inc_ok && !w_dec_ok) begin
            r_cnt <= r_cnt + C_ONE;
        end else if (w_dec_ok && !w_inc_ok) begin
            r_cnt <= r_cnt - C_ONE;
        end
    end

endmodule : ysyx_25040111_sb_cnt
`default_nettype wire

// File: rtl/ysyx_25040111_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_scoreboard
// Purpose  : In-order issue scoreboard. Tracks outstanding writes per
//            architectural register and stalls issue on RAW hazards or when a
//            destination already has the maximum number of pending writes.
//            clock, reset (async, active low)
//            sb    - decode/execute/write-back handshake (slave modport)
//            busy  - bit r set while register r has pending writes
//            idle  - no pending writes anywhere
//            err   - sticky: a retire arrived for a register with none pending
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25040111_scoreboard
    import ysyx_25040111_scoreboard_pkg::*;
#(
    parameter int NREG  = SB_NREG,
    parameter int CNT_W = SB_CNT_W
) (
    input  wire logic                   clock,
    input  wire logic                   reset,
    ysyx_25040111_scoreboard_if.slave   sb,
    output logic [NREG-1:0]             busy,
    output logic                        idle,
    output logic                        err
);

    localparam int IDX_W = $clog2(NREG);

    logic [IDX_W-1:0] w_rs1_idx;
    logic [IDX_W-1:0] w_rs2_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wb_idx;

    logic [NREG-1:0]  w_zero;
    logic [NREG-1:0]  w_full;
    logic [NREG-1:0]  w_inc;
    logic [NREG-1:0]  w_dec;

    logic             w_hazard;
    logic             w_fire;
    logic             w_retire;
    logic             r_err;
    logic             w_unused_ok;

    // High index bits are ignored: x16..x31 alias onto x0..x15.
    assign w_rs1_idx = sb.id_rs1[IDX_W-1:0];
    assign w_rs2_idx = sb.id_rs2[IDX_W-1:0];
    assign w_rd_idx  = sb.id_rd[IDX_W-1:0];
    assign w_wb_idx  = sb.wb_rd[IDX_W-1:0];

    // Hazard looks only at registered counts, so a retire this cycle does
    // not unblock a dependent instruction until the following cycle.
    assign w_hazard = (sb.id_rs1_en & (w_rs1_idx != '0) & ~w_zero[w_rs1_idx])
                    | (sb.id_rs2_en & (w_rs2_idx != '0) & ~w_zero[w_rs2_idx])
                    | (sb.id_rd_en  & (w_rd_idx  != '0) &  w_full[w_rd_idx]);

    assign sb.ex_valid = sb.id_valid & ~w_hazard;
    assign sb.id_ready = sb.ex_ready & ~w_hazard;
    assign w_fire      = sb.id_valid & sb.id_ready;
    assign w_retire    = sb.wb_valid & (w_wb_idx != '0);

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (w_fire && sb.id_rd_en && (w_rd_idx != '0)) begin
            w_inc[w_rd_idx] = 1'b1;
        end
        if (w_retire) begin
            w_dec[w_wb_idx] = 1'b1;
        end
    end

    // x0 is hard-wired: never pending, never full.
    assign w_zero[0] = 1'b1;
    assign w_full[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        ysyx_25040111_sb_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clock (clock),
            .reset (reset),
            .inc   (w_inc[r]),
            .dec   (w_dec[r]),
            .zero  (w_zero[r]),
            .full  (w_full[r])
        );
    end

    // A retire with nothing pending is a pipeline bug upstream; remember it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_retire && w_zero[w_wb_idx]) begin
            r_err <= 1'b1;
        end
    end

    assign busy = ~w_zero;
    assign idle = &w_zero;
    assign err  = r_err;

    assign w_unused_ok = ^{sb.id_rs1, sb.id_rs2, sb.id_rd, sb.wb_rd,
                           w_inc[0], w_dec[0]};

endmodule : ysyx_25040111_scoreboard
`default_nettype wire

// File: tb/tb_ysyx_25040111_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25040111_scoreboard
// Purpose  : Self-checking bench for ysyx_25040111_scoreboard: a directed
//            vector table, hand-written multi-cycle sequences and a
//            randomized run checked against a per-register count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040111_scoreboard;

    localparam int NREG    = 16;
    localparam int CNT_MAX = 3;

    logic            clock;
    logic            reset;
    logic [NREG-1:0] busy;
    logic            idle;
    logic            err;

    int checks = 0;
    int passed = 0;

    ysyx_25040111_scoreboard_if sb_if ();

    ysyx_25040111_scoreboard #(.NREG(NREG), .CNT_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .sb    (sb_if),
        .busy  (busy),
        .idle  (idle),
        .err   (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iv;
        logic [4:0]  rs1;
        logic        e1;
        logic [4:0]  rs2;
        logic        e2;
        logic [4:0]  rd;
        logic        ed;
        logic        exr;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        x_ready;
        logic        x_exv;
        logic [15:0] x_busy;
        logic        x_idle;
        logic        x_err;
    } vec_t;

    vec_t vecs[11];

    task automatic drive(input logic iv, input logic [4:0] rs1, input logic e1,
                         input logic [4:0] rs2, input logic e2,
                         input logic [4:0] rd, input logic ed,
                         input logic exr, input logic wbv, input logic [4:0] wbrd);
        sb_if.id_valid  = iv;
        sb_if.id_rs1    = rs1;
        sb_if.id_rs1_en = e1;
        sb_if.id_rs2    = rs2;
        sb_if.id_rs2_en = e2;
        sb_if.id_rd     = rd;
        sb_if.id_rd_en  = ed;
        sb_if.ex_ready  = exr;
        sb_if.wb_valid  = wbv;
        sb_if.wb_rd     = wbrd;
    endtask

    task automatic drive_idle(input logic exr);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, exr, 1'b0, 5'd0);
    endtask

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic logic [19:0] observe();
        return {sb_if.id_ready, sb_if.ex_valid, busy, idle, err};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive_idle(1'b1);
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    // Behavioural reference: outstanding writes per register.
    int m_cnt[NREG];
    bit m_err;

    function automatic bit m_hazard(input logic [4:0] rs1, input logic e1,
                                    input logic [4:0] rs2, input logic e2,
                                    input logic [4:0] rd, input logic ed);
        int a, b, d;
        a = rs1 % NREG;
        b = rs2 % NREG;
        d = rd % NREG;
        return (e1 && a != 0 && m_cnt[a] > 0) ||
               (e2 && b != 0 && m_cnt[b] > 0) ||
               (ed && d != 0 && m_cnt[d] == CNT_MAX);
    endfunction

    initial begin
        reset = 1'b0;
        drive_idle(1'b1);
        #3;
        check("reset_state", observe(), {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
        @(negedge clock);
        reset = 1'b1;
        tick();

        // iv rs1 e1 rs2 e2 rd e1 exr wbv wbrd | ready exv busy idle err
        vecs[0]  = '{1, 0, 0, 0, 0, 5, 1, 1, 0, 0,  1, 1, 16'h0000, 1, 0};
        vecs[1]  = '{1, 5, 1, 0, 0, 6, 1, 1, 0, 0,  0, 0, 16'h0020, 0, 0};
        vecs[2]  = '{1, 5, 1, 0, 0, 6, 1, 1, 1, 5,  0, 0, 16'h0020, 0, 0};
        vecs[3]  = '{1, 5, 1, 0, 0, 6, 1, 1, 0, 0,  1, 1, 16'h0000, 1, 0};
        vecs[4]  = '{1, 0, 0, 6, 1, 0, 0, 0, 0, 0,  0, 0, 16'h0040, 0, 0};
        vecs[5]  = '{1, 22, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0040, 0, 0};
        vecs[6]  = '{0, 6, 1, 0, 0, 0, 0, 1, 1, 6,  0, 0, 16'h0040, 0, 0};
        vecs[7]  = '{1, 0, 1, 16, 1, 0, 1, 1, 0, 0, 1, 1, 16'h0000, 1, 0};
        vecs[8]  = '{1, 0, 0, 0, 0, 6, 1, 0, 0, 0,  0, 1, 16'h0000, 1, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 9,  1, 0, 16'h0000, 1, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 16'h0000, 1, 1};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].iv, vecs[i].rs1, vecs[i].e1, vecs[i].rs2, vecs[i].e2,
                  vecs[i].rd, vecs[i].ed, vecs[i].exr, vecs[i].wbv, vecs[i].wbrd);
            @(negedge clock);
            check($sformatf("vec%0d", i), observe(),
                  {vecs[i].x_ready, vecs[i].x_exv, vecs[i].x_busy, vecs[i].x_idle, vecs[i].x_err});
            tick();
        end

        // WAW saturation on x3.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
            @(negedge clock);
            check($sformatf("waw_issue%0d", k), {19'd0, sb_if.id_ready}, 20'd1);
            tick();
        end
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
        @(negedge clock);
        check("waw_full", {18'd0, sb_if.id_ready, busy[3]}, 20'b01);
        tick();
        drive(1, 0, 0, 0, 0, 3, 1, 1, 1, 3);
        @(negedge clock);
        check("waw_no_bypass", {19'd0, sb_if.id_ready}, 20'd0);
        tick();
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
        @(negedge clock);
        check("waw_accept", {19'd0, sb_if.id_ready}, 20'd1);
        tick();
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
        @(negedge clock);
        check("waw_refull", {19'd0, sb_if.id_ready}, 20'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
            tick();
        end
        drive_idle(1'b1);
        @(negedge clock);
        check("waw_drained", observe(), {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
        tick();

        // Same-cycle fire and retire on x7.
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 1, 7);
        @(negedge clock);
        check("same_reg_fire", {19'd0, sb_if.id_ready}, 20'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
        @(negedge clock);
        check("same_reg_hold", {2'b00, busy, idle, err}, {2'b00, 16'h0080, 1'b0, 1'b0});
        tick();
        drive_idle(1'b1);
        @(negedge clock);
        check("same_reg_clear", {2'b00, busy, idle, err}, {2'b00, 16'h0000, 1'b1, 1'b0});
        tick();

        // Asynchronous reset mid-cycle with x4 pending twice and err set.
        do_reset();
        drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 4, 1, 1, 1, 9);
        tick();
        drive_idle(1'b1);
        #1;
        check("pre_async_reset", {2'b00, busy, idle, err}, {2'b00, 16'h0010, 1'b0, 1'b1});
        reset = 1'b0;
        #1;
        check("async_reset", {2'b00, busy, idle, err}, {2'b00, 16'h0000, 1'b1, 1'b0});
        @(negedge clock);
        reset = 1'b1;
        tick();
        drive(1, 4, 1, 0, 0, 4, 1, 1, 0, 0);
        @(negedge clock);
        check("after_reset_issue", observe(), {1'b1, 1'b1, 16'h0000, 1'b1, 1'b0});
        tick();

        // Randomized run against the count model.
        do_reset();
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
        m_err = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic        iv, e1, e2, ed, exr, wbv, hz, fire;
            logic [4:0]  rs1, rs2, rd, wbrd;
            logic [15:0] xb;
            int          n_cnt[NREG];
            int          d, w;
            iv   = $urandom_range(0, 3) != 0;
            rs1  = 5'($urandom_range(0, 5) | ($urandom_range(0, 3) == 0 ? 16 : 0));
            rs2  = 5'($urandom_range(0, 5) | ($urandom_range(0, 3) == 0 ? 16 : 0));
            rd   = 5'($urandom_range(0, 5) | ($urandom_range(0, 3) == 0 ? 16 : 0));
            e1   = $urandom_range(0, 2) == 0;
            e2   = $urandom_range(0, 3) == 0;
            ed   = $urandom_range(0, 3) != 0;
            exr  = $urandom_range(0, 3) != 0;
            wbv  = $urandom_range(0, 2) == 0;
            wbrd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) < 9) begin
                int start;
                start = $urandom_range(0, NREG - 1);
                for (int j = 0; j < NREG; j++) begin
                    if (m_cnt[(start + j) % NREG] > 0) begin
                        wbrd = 5'((start + j) % NREG);
                        break;
                    end
                end
            end
            drive(iv, rs1, e1, rs2, e2, rd, ed, exr, wbv, wbrd);
            hz = m_hazard(rs1, e1, rs2, e2, rd, ed);
            xb = '0;
            for (int r = 0; r < NREG; r++) xb[r] = m_cnt[r] != 0;
            @(negedge clock);
            check($sformatf("rand%0d", cyc), observe(),
                  {exr & ~hz, iv & ~hz, xb, xb == 16'h0, m_err});
            fire = iv & exr & ~hz;
            for (int r = 0; r < NREG; r++) n_cnt[r] = m_cnt[r];
            d = rd % NREG;
            w = wbrd % NREG;
            if (fire && ed && d != 0) n_cnt[d]++;
            if (wbv && w != 0) begin
                if (m_cnt[w] == 0) m_err = 1;
                else n_cnt[w]--;
            end
            for (int r = 0; r < NREG; r++) m_cnt[r] = n_cnt[r];
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_ysyx_25040111_scoreboard
`default_nettype wire
